edc_secded: RTL and testbench

Parametrised SECDED (single-error-correct, double-error-detect) Hamming encoder/decoder that replaces the pass-through EDC generator on the Wishbone memory data path. The encode path produces check bits for write data. The decode path checks and corrects read data, flags uncorrectable words, and keeps saturating error counters. Both paths are one-stage registered pipelines with valid-only flow, and they sit between the Wishbone master data bus and main memory storage.

---
 rtl/edc_secded.sv | 161 ++++++++++++++++
 tb/tb_edc_secded.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edc_secded.sv
`default_nettype none
// edc_secded: one-stage registered SECDED Hamming encode/decode paths with
// saturating corrected/uncorrectable error counters and a bypass mode.
module edc_secded #(
  parameter int WB_DWIDTH = 32,
  parameter int CHK_WIDTH = 7,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_edc_en,
  input  logic                 i_enc_valid,
  input  logic [WB_DWIDTH-1:0] i_enc_dat,
  output logic                 o_enc_valid,
  output logic [WB_DWIDTH-1:0] o_enc_dat,
  output logic [CHK_WIDTH-1:0] o_enc_chk,
  input  logic                 i_dec_valid,
  input  logic [WB_DWIDTH-1:0] i_dec_dat,
  input  logic [CHK_WIDTH-1:0] i_dec_chk,
  output logic                 o_dec_valid,
  output logic [WB_DWIDTH-1:0] o_dec_dat,
  output logic                 o_dec_sbe,
  output logic                 o_dec_dbe,
  output logic [CHK_WIDTH-1:0] o_dec_syn,
  input  logic                 i_cnt_clr,
  output logic [CNT_WIDTH-1:0] o_sbe_cnt,
  output logic [CNT_WIDTH-1:0] o_dbe_cnt
);

  localparam int R    = CHK_WIDTH - 1;
  localparam int NPOS = WB_DWIDTH + R;
  localparam logic [R-1:0]         NPOS_V  = R'(NPOS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic int min_r(input int n);
    int r;
    r = 0;
    for (int k = 16; k >= 1; k--)
      if ((1 << k) >= n + k + 1) r = k;
    return r;
  endfunction

  // Codeword position of data bit j: the j-th non-power-of-two position.
  function automatic int data_pos(input int j);
    int k;
    int pos;
    k   = 0;
    pos = 0;
    for (int q = 1; q <= NPOS; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (k == j) pos = q;
        k++;
      end
    end
    return pos;
  endfunction

  function automatic logic [WB_DWIDTH-1:0] ham_mask(input int i);
    logic [WB_DWIDTH-1:0] m;
    m = '0;
    for (int j = 0; j < WB_DWIDTH; j++)
      m[j] = ((data_pos(j) >> i) & 1) == 1;
    return m;
  endfunction

  if (!((WB_DWIDTH == 8 || WB_DWIDTH == 16 || WB_DWIDTH == 32 || WB_DWIDTH == 64)
        && R == min_r(WB_DWIDTH))) begin : g_bad_param
    $error("edc_secded: unsupported WB_DWIDTH/CHK_WIDTH combination");
  end

  logic [R-1:0]         enc_ham;
  logic [R-1:0]         dec_ham;
  logic [R-1:0]         dec_s;
  logic                 dec_p;
  logic [WB_DWIDTH-1:0] syn_hit;
  logic                 sbe_n;
  logic                 dbe_n;
  logic [WB_DWIDTH-1:0] fix;

  for (genvar i = 0; i < R; i++) begin : g_ham
    localparam logic [WB_DWIDTH-1:0] MASK = ham_mask(i);
    assign enc_ham[i] = ^(i_enc_dat & MASK);
    assign dec_ham[i] = ^(i_dec_dat & MASK);
  end

  for (genvar j = 0; j < WB_DWIDTH; j++) begin : g_hit
    localparam logic [R-1:0] POS_V = R'(data_pos(j));
    assign syn_hit[j] = (dec_s == POS_V);
  end

  assign dec_s = dec_ham ^ i_dec_chk[R-1:0];
  assign dec_p = ^{i_dec_dat, i_dec_chk};

  // A syndrome beyond the last codeword position cannot come from one flip.
  always_comb begin
    sbe_n = 1'b0;
    dbe_n = 1'b0;
    fix   = '0;
    if (dec_p) begin
      sbe_n = (dec_s <= NPOS_V);
      dbe_n = (dec_s >  NPOS_V);
    end else begin
      dbe_n = (dec_s != '0);
    end
    if (sbe_n) fix = syn_hit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_enc_valid <= 1'b0;
      o_enc_dat   <= '0;
      o_enc_chk   <= '0;
    end else begin
      o_enc_valid <= i_enc_valid;
      if (i_enc_valid) begin
        o_enc_dat <= i_enc_dat;
        o_enc_chk <= i_edc_en ? {^{i_enc_dat, enc_ham}, enc_ham} : '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dec_valid <= 1'b0;
      o_dec_dat   <= '0;
      o_dec_sbe   <= 1'b0;
      o_dec_dbe   <= 1'b0;
      o_dec_syn   <= '0;
    end else begin
      o_dec_valid <= i_dec_valid;
      if (i_dec_valid) begin
        if (i_edc_en) begin
          o_dec_dat <= i_dec_dat ^ fix;
          o_dec_sbe <= sbe_n;
          o_dec_dbe <= dbe_n;
          o_dec_syn <= {dec_p, dec_s};
        end else begin
          o_dec_dat <= i_dec_dat;
          o_dec_sbe <= 1'b0;
          o_dec_dbe <= 1'b0;
          o_dec_syn <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sbe_cnt <= '0;
      o_dbe_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_sbe_cnt <= '0;
      o_dbe_cnt <= '0;
    end else begin
      if (o_dec_valid && o_dec_sbe && !(&o_sbe_cnt)) o_sbe_cnt <= o_sbe_cnt + CNT_ONE;
      if (o_dec_valid && o_dec_dbe && !(&o_dbe_cnt)) o_dbe_cnt <= o_dbe_cnt + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edc_secded.sv
`default_nettype none
// tb_edc_secded: table vectors, hand sequences and randomised round-trips
// checked against a codeword-level SECDED reference model.
module tb_edc_secded;

  localparam int DW = 32;
  localparam int CW = 7;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          edc_en = 1'b0;
  logic          enc_valid = 1'b0;
  logic [DW-1:0] enc_dat = '0;
  logic          dec_valid = 1'b0;
  logic [DW-1:0] dec_dat = '0;
  logic [CW-1:0] dec_chk = '0;
  logic          cnt_clr = 1'b0;
  logic          o_enc_valid, o_dec_valid, o_dec_sbe, o_dec_dbe;
  logic [DW-1:0] o_enc_dat, o_dec_dat;
  logic [CW-1:0] o_enc_chk, o_dec_syn;
  logic [NW-1:0] o_sbe_cnt, o_dbe_cnt;

  edc_secded #(.WB_DWIDTH(DW), .CHK_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_edc_en(edc_en),
    .i_enc_valid(enc_valid), .i_enc_dat(enc_dat),
    .o_enc_valid(o_enc_valid), .o_enc_dat(o_enc_dat), .o_enc_chk(o_enc_chk),
    .i_dec_valid(dec_valid), .i_dec_dat(dec_dat), .i_dec_chk(dec_chk),
    .o_dec_valid(o_dec_valid), .o_dec_dat(o_dec_dat), .o_dec_sbe(o_dec_sbe),
    .o_dec_dbe(o_dec_dbe), .o_dec_syn(o_dec_syn),
    .i_cnt_clr(cnt_clr), .o_sbe_cnt(o_sbe_cnt), .o_dbe_cnt(o_dbe_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: place bits in a 1..38 codeword; syndrome is XOR of set positions.
  function automatic logic [CW-1:0] m_encode(input logic [DW-1:0] d);
    int syn;
    int j;
    logic [CW-1:0] c;
    syn = 0;
    j = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[j]) syn = syn ^ p;
        j++;
      end
    end
    c[5:0] = syn[5:0];
    c[6]   = (($countones(d) + $countones(syn[5:0])) % 2) == 1;
    return c;
  endfunction

  task automatic m_decode(input logic [DW-1:0] d, input logic [CW-1:0] c,
                          output logic [DW-1:0] od, output logic sbe,
                          output logic dbe, output logic [CW-1:0] syn);
    logic cw[1:38];
    int j, k, s;
    logic par;
    j = 0; k = 0; s = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) == 0) begin cw[p] = c[k]; k++; end
      else begin cw[p] = d[j]; j++; end
      if (cw[p]) s = s ^ p;
    end
    par = (($countones(d) + $countones(c)) % 2) == 1;
    sbe = par && (s <= 38);
    dbe = (par && (s > 38)) || (!par && (s != 0));
    if (sbe && s != 0) cw[s] = ~cw[s];
    j = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin od[j] = cw[p]; j++; end
    syn = {par, s[5:0]};
  endtask

  logic          e_ev = 0, e_dv = 0, e_dsbe = 0, e_ddbe = 0;
  logic [DW-1:0] e_edat = '0, e_ddat = '0;
  logic [CW-1:0] e_echk = '0, e_dsyn = '0;
  int            m_sbe_cnt = 0, m_dbe_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sbe_cnt = 0;
      m_dbe_cnt = 0;
    end else if (cnt_clr) begin
      m_sbe_cnt = 0;
      m_dbe_cnt = 0;
    end else begin
      if (e_dv && e_dsbe && m_sbe_cnt < 15) m_sbe_cnt++;
      if (e_dv && e_ddbe && m_dbe_cnt < 15) m_dbe_cnt++;
    end
  end

  task automatic check_all();
    check("enc_valid", o_enc_valid, e_ev);
    check("enc_dat", o_enc_dat, e_edat);
    check("enc_chk", o_enc_chk, e_echk);
    check("dec_valid", o_dec_valid, e_dv);
    check("dec_dat", o_dec_dat, e_ddat);
    check("dec_sbe", o_dec_sbe, e_dsbe);
    check("dec_dbe", o_dec_dbe, e_ddbe);
    check("dec_syn", o_dec_syn, e_dsyn);
    check("sbe_cnt", o_sbe_cnt, m_sbe_cnt[NW-1:0]);
    check("dbe_cnt", o_dbe_cnt, m_dbe_cnt[NW-1:0]);
  endtask

  task automatic step(input logic en, input logic ev, input logic [DW-1:0] ed,
                      input logic dv, input logic [DW-1:0] dd, input logic [CW-1:0] dc,
                      input logic clr);
    @(negedge clk);
    edc_en = en; enc_valid = ev; enc_dat = ed;
    dec_valid = dv; dec_dat = dd; dec_chk = dc; cnt_clr = clr;
    @(posedge clk);
    #1;
    e_ev = ev;
    if (ev) begin
      e_edat = ed;
      e_echk = en ? m_encode(ed) : '0;
    end
    e_dv = dv;
    if (dv) begin
      if (en) m_decode(dd, dc, e_ddat, e_dsbe, e_ddbe, e_dsyn);
      else begin e_ddat = dd; e_dsbe = 0; e_ddbe = 0; e_dsyn = '0; end
    end
    check_all();
  endtask

  task automatic idle(input logic clr);
    step(1'b1, 1'b0, '0, 1'b0, '0, '0, clr);
  endtask

  typedef struct {
    logic          en;
    logic [DW-1:0] dat;
    logic [CW-1:0] chk;
    logic [DW-1:0] x_dat;
    logic          x_sbe;
    logic          x_dbe;
    logic [CW-1:0] x_syn;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0000, 7'h43, 32'h0000_0001, 1'b1, 1'b0, 7'h43};
    vecs[1] = '{1'b1, 32'h0000_0003, 7'h00, 32'h0000_0003, 1'b0, 1'b1, 7'h06};
    vecs[2] = '{1'b0, 32'hDEAD_BEEF, 7'h7F, 32'hDEAD_BEEF, 1'b0, 1'b0, 7'h00};
    vecs[3] = '{1'b1, 32'h0000_0000, 7'h00, 32'h0000_0000, 1'b0, 1'b0, 7'h00};
    vecs[4] = '{1'b1, 32'h0000_0000, 7'h40, 32'h0000_0000, 1'b1, 1'b0, 7'h40};
    vecs[5] = '{1'b1, 32'h0000_0000, 7'h01, 32'h0000_0000, 1'b1, 1'b0, 7'h41};
    vecs[6] = '{1'b1, 32'h0000_0000, 7'h7F, 32'h0000_0000, 1'b0, 1'b1, 7'h7F};
    vecs[7] = '{1'b1, 32'h0000_0000, 7'h26, 32'h8000_0000, 1'b1, 1'b0, 7'h66};

    repeat (3) @(posedge clk);
    #1;
    check_all();
    check("reset_outputs", {o_enc_valid, o_dec_valid, o_dec_sbe, o_dec_dbe, o_enc_chk,
                            o_dec_syn, o_sbe_cnt, o_dbe_cnt}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Encode test-plan values and one-cycle valid.
    step(1'b1, 1'b1, 32'h0, 1'b0, '0, '0, 1'b0);
    check("enc_zero", o_enc_chk, 7'h00);
    step(1'b1, 1'b1, 32'h1, 1'b0, '0, '0, 1'b0);
    check("enc_one", o_enc_chk, 7'h43);
    check("enc_one_valid", o_enc_valid, 1'b1);
    idle(1'b0);
    check("enc_valid_drop", o_enc_valid, 1'b0);

    // Single and double error with counter follow-up.
    step(1'b1, 1'b0, '0, 1'b1, 32'h0, 7'h43, 1'b0);
    check("sbe_data", o_dec_dat, 32'h1);
    idle(1'b0);
    check("sbe_cnt_one", o_sbe_cnt, 4'd1);
    step(1'b1, 1'b0, '0, 1'b1, 32'h3, 7'h00, 1'b0);
    check("dbe_syn", o_dec_syn, 7'h06);
    idle(1'b0);
    check("dbe_cnt_one", o_dbe_cnt, 4'd1);

    // Table vectors, including bypass.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].en, 1'b0, '0, 1'b1, vecs[i].dat, vecs[i].chk, 1'b0);
      check($sformatf("vec%0d_dat", i), o_dec_dat, vecs[i].x_dat);
      check($sformatf("vec%0d_sbe", i), o_dec_sbe, vecs[i].x_sbe);
      check($sformatf("vec%0d_dbe", i), o_dec_dbe, vecs[i].x_dbe);
      check($sformatf("vec%0d_syn", i), o_dec_syn, vecs[i].x_syn);
    end
    idle(1'b0);

    // Bypass encode yields zero check bits.
    step(1'b0, 1'b1, 32'h1, 1'b0, '0, '0, 1'b0);
    check("bypass_enc", o_enc_chk, 7'h00);

    // Randomised round-trip with 0, 1 or 2 flips, both paths concurrently.
    idle(1'b1);
    for (int it = 0; it < 10000; it++) begin
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic [38:0]   cw;
      int nf, a, b;
      d  = $urandom;
      c  = m_encode(d);
      cw = {c, d};
      nf = $urandom_range(0, 2);
      a  = $urandom_range(0, 38);
      b  = (a + $urandom_range(1, 38)) % 39;
      if (nf >= 1) cw[a] = ~cw[a];
      if (nf == 2) cw[b] = ~cw[b];
      step(1'b1, 1'b1, d, 1'b1, cw[31:0], cw[38:32], 1'b0);
      if (nf == 0) begin
        check("rt0_dat", o_dec_dat, d);
        check("rt0_flags", {o_dec_sbe, o_dec_dbe}, 2'b00);
      end else if (nf == 1) begin
        check("rt1_dat", o_dec_dat, d);
        check("rt1_flags", {o_dec_sbe, o_dec_dbe}, 2'b10);
      end else begin
        check("rt2_flags", {o_dec_sbe, o_dec_dbe}, 2'b01);
      end
    end

    // Counter saturation then clear racing an sbe result.
    idle(1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0, 1'b1, 32'h0, 7'h43, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("sbe_cnt_sat", o_sbe_cnt, 4'd15);
    step(1'b1, 1'b0, '0, 1'b1, 32'h0, 7'h43, 1'b0);
    idle(1'b1);
    check("sbe_cnt_clr", o_sbe_cnt, 4'd0);
    step(1'b1, 1'b0, '0, 1'b1, 32'h0, 7'h43, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("sbe_cnt_after_clr", o_sbe_cnt, 4'd1);

    // Asynchronous reset in the middle of a request stream.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h1234_0000 + i, 1'b1, 32'h0, 7'h43, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    e_ev = 0; e_edat = '0; e_echk = '0;
    e_dv = 0; e_ddat = '0; e_dsbe = 0; e_ddbe = 0; e_dsyn = '0;
    check("rst_async", {o_enc_valid, o_enc_dat, o_enc_chk, o_dec_valid, o_dec_dat,
                        o_dec_sbe, o_dec_dbe, o_dec_syn, o_sbe_cnt, o_dbe_cnt}, '0);
    @(negedge clk);
    enc_valid = 0;
    dec_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    step(1'b1, 1'b1, 32'hCAFE_0001, 1'b1, 32'h3, 7'h00, 1'b0);
    check("resume_enc_dat", o_enc_dat, 32'hCAFE_0001);
    check("resume_dbe", o_dec_dbe, 1'b1);
    idle(1'b0);
    check("resume_dbe_cnt", o_dbe_cnt, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
